// File: rtl/note_recorder_if.sv
// Song RAM write port: one {dur, note} record per strobe.
interface note_recorder_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DUR_W  = 12
);
    localparam int unsigned DATA_W = DUR_W + 10;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/note_recorder.sv
// Records held piano key patterns as {duration, note} entries into the song RAM,
// closing each take with an all-zero terminator that the playback reader stops on.
module note_recorder #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_MS = 10,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DUR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_en,
    input  logic [9:0]        pin_note,
    note_recorder_if.master   wr,
    output logic [ADDR_W:0]   rec_len,
    output logic              recording,
    output logic              full
);
    localparam int unsigned NOTE_W    = 10;
    localparam int unsigned DATA_W    = DUR_W + NOTE_W;
    localparam int unsigned LEN_W     = ADDR_W + 1;
    localparam int unsigned TICK_CYC  = CLK_HZ / 1000 * TICK_MS;
    localparam int unsigned CNT_W     = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int unsigned LAST_SLOT = (2 ** ADDR_W) - 1;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, FLUSH, TERM} state_t;

    state_t state, next_state;

    logic [1:0]        rec_sync;
    logic              rec_en_q;
    logic [NOTE_W-1:0] note_s1, note_s2, note_d;

    logic [NOTE_W-1:0] cur, cur_n;
    logic [DUR_W-1:0]  dur, dur_n, dur_eff;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              tick_wrap, note_chg, room;
    logic [LEN_W-1:0]  count_eff;
    logic              we_n, rec_n, rec_strobe, recording_n;
    logic [DATA_W-1:0] wdata_n;

    // Two-flop synchronisers; note_d aligns the key path with the rec_en edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_sync <= '0;
            rec_en_q <= 1'b0;
            note_s1  <= '0;
            note_s2  <= '0;
            note_d   <= '0;
        end else begin
            rec_sync <= {rec_sync[0], rec_en};
            rec_en_q <= rec_sync[1];
            note_s1  <= pin_note;
            note_s2  <= note_s1;
            note_d   <= note_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A tick completing on this edge is credited to the record closed on this edge.
    assign tick_wrap = (cnt == CNT_W'(TICK_CYC - 1));
    assign dur_eff   = dur + DUR_W'(tick_wrap);
    assign note_chg  = (note_d != cur);
    assign count_eff = rec_len + LEN_W'(rec_strobe);
    assign room      = (count_eff < LEN_W'(LAST_SLOT));

    always_comb begin
        next_state = state;
        cur_n      = cur;
        dur_n      = dur;
        cnt_n      = cnt;
        we_n       = 1'b0;
        rec_n      = 1'b0;
        wdata_n    = '0;

        case (state)
            IDLE: begin
                if (rec_sync[1] && !rec_en_q) next_state = ARM;
            end
            ARM: begin
                cur_n      = note_d;
                dur_n      = '0;
                cnt_n      = '0;
                next_state = CAPTURE;
            end
            CAPTURE: begin
                cnt_n = tick_wrap ? '0 : cnt + CNT_W'(1);
                if (note_chg) begin
                    // Patterns shorter than one tick are dropped as glitches.
                    if (dur_eff != '0 && room) begin
                        we_n    = 1'b1;
                        rec_n   = 1'b1;
                        wdata_n = {dur_eff, cur};
                    end
                    cur_n = note_d;
                    dur_n = '0;
                    cnt_n = '0;
                end else if (tick_wrap) begin
                    if (dur_eff == DUR_MAX) begin
                        if (room) begin
                            we_n    = 1'b1;
                            rec_n   = 1'b1;
                            wdata_n = {DUR_MAX, cur};
                        end
                        dur_n = '0;
                    end else begin
                        dur_n = dur_eff;
                    end
                end
                if (!rec_sync[1] || !room) next_state = FLUSH;
            end
            FLUSH: begin
                if (dur_eff != '0 && room) begin
                    we_n    = 1'b1;
                    rec_n   = 1'b1;
                    wdata_n = {dur_eff, cur};
                end
                next_state = TERM;
            end
            TERM: begin
                we_n       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Held through the terminator strobe so the LED spans every write of the take.
        recording_n = (next_state != IDLE) || (state == TERM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= '0;
            dur        <= '0;
            cnt        <= '0;
            rec_strobe <= 1'b0;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
            rec_len    <= '0;
            full       <= 1'b0;
            recording  <= 1'b0;
        end else begin
            cur        <= cur_n;
            dur        <= dur_n;
            cnt        <= cnt_n;
            rec_strobe <= rec_n;
            wr.wr_en   <= we_n;
            wr.wr_data <= wdata_n;
            recording  <= recording_n;
            // Address and length advance after each record strobe; the terminator does not count.
            if (state == ARM) begin
                wr.wr_addr <= '0;
                rec_len    <= '0;
                full       <= 1'b0;
            end else if (rec_strobe) begin
                wr.wr_addr <= wr.wr_addr + ADDR_W'(1);
                rec_len    <= rec_len + LEN_W'(1);
                full       <= ((rec_len + LEN_W'(1)) == LEN_W'(LAST_SLOT));
            end
        end
    end
endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: scoreboarded RAM writes plus timing and status checks.
module tb_note_recorder;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DUR_W  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            rec_en;
    logic [9:0]      pin_note;
    logic [ADDR_W:0] rec_len;
    logic            recording;
    logic            full;

    note_recorder_if #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) wr ();

    note_recorder #(
        .CLK_HZ(10_000), .TICK_MS(1), .ADDR_W(ADDR_W), .DUR_W(DUR_W)
    ) dut (
        .clk(clk), .rst(rst), .rec_en(rec_en), .pin_note(pin_note),
        .wr(wr), .rec_len(rec_len), .recording(recording), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rec;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input int addr, input int dur, input logic [9:0] note, input int at);
        exp_t e;
        e.rec = 32'({ADDR_W'(addr), DUR_W'(dur), note});
        e.at  = at;
        exp_q.push_back(e);
    endtask

    // Returns just after edge n-1 so the next assignment lands before edge n.
    task automatic before_edge(input int n);
        while (cyc < n - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wr_en"},     32'(wr.wr_en),   32'd0);
        check({tag, "_wr_addr"},   32'(wr.wr_addr), 32'd0);
        check({tag, "_wr_data"},   32'(wr.wr_data), 32'd0);
        check({tag, "_rec_len"},   32'(rec_len),    32'd0);
        check({tag, "_recording"}, 32'(recording),  32'd0);
        check({tag, "_full"},      32'(full),       32'd0);
    endtask

    // Every RAM write must match the head of the scoreboard, in content and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (wr.wr_en === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) passes++;
            else $error("FAIL wr_unexpected: observed addr %0d data 0x%0h expected no write",
                        wr.wr_addr, wr.wr_data);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_record", 32'({wr.wr_addr, wr.wr_data}), e.rec);
                check("wr_cycle",  32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst = 1'b1; rec_en = 1'b0; pin_note = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        before_edge(cyc + 5);

        // Basic take: 50 clocks of 0x001, 30 clocks of 0x204.
        b = cyc + 1;
        rec_en = 1'b1; pin_note = 10'h001;
        push(0, 5, 10'h001, b + 53);
        push(1, 3, 10'h204, b + 83);
        push(2, 0, 10'h000, b + 84);
        before_edge(b + 2);
        check("rec_rise_early", 32'(recording), 32'd0);
        before_edge(b + 3);
        check("rec_rise", 32'(recording), 32'd1);
        before_edge(b + 50);
        pin_note = 10'h204;
        before_edge(b + 80);
        rec_en = 1'b0;
        before_edge(b + 85);
        check("rec_hold_term", 32'(recording), 32'd1);
        before_edge(b + 86);
        check("rec_fall", 32'(recording), 32'd0);
        check("basic_len", 32'(rec_len), 32'd2);
        check("basic_full", 32'(full), 32'd0);
        check("basic_drained", 32'(exp_q.size()), 32'd0);
        before_edge(cyc + 10);

        // Glitch: a 4-clock 0x002 pulse inside 0x001 leaves no record.
        b = cyc + 1;
        rec_en = 1'b1; pin_note = 10'h001;
        push(0, 4, 10'h001, b + 43);
        push(1, 3, 10'h001, b + 77);
        push(2, 0, 10'h000, b + 78);
        before_edge(b + 40);
        pin_note = 10'h002;
        before_edge(b + 44);
        pin_note = 10'h001;
        before_edge(b + 74);
        rec_en = 1'b0;
        before_edge(b + 90);
        check("glitch_len", 32'(rec_len), 32'd2);
        check("glitch_drained", 32'(exp_q.size()), 32'd0);

        // Saturation: 20 ticks of 0x010 split at the 4-bit duration limit.
        b = cyc + 1;
        rec_en = 1'b1; pin_note = 10'h010;
        push(0, 15, 10'h010, b + 153);
        push(1, 5,  10'h010, b + 203);
        push(2, 0,  10'h000, b + 204);
        before_edge(b + 200);
        rec_en = 1'b0;
        before_edge(b + 215);
        check("sat_len", 32'(rec_len), 32'd2);
        check("sat_drained", 32'(exp_q.size()), 32'd0);

        // Full: ten 2-tick notes into an 8-slot RAM.
        b = cyc + 1;
        rec_en = 1'b1;
        for (int i = 0; i < 7; i++) push(i, 2, 10'(1 << i), b + 20 * (i + 1) + 3);
        push(7, 0, 10'h000, b + 146);
        for (int i = 0; i < 10; i++) begin
            before_edge(b + 20 * i);
            pin_note = 10'(1 << i);
        end
        before_edge(b + 201);
        check("full_flag", 32'(full), 32'd1);
        check("full_len", 32'(rec_len), 32'd7);
        check("full_rec_off", 32'(recording), 32'd0);
        check("full_drained", 32'(exp_q.size()), 32'd0);
        rec_en = 1'b0;
        before_edge(cyc + 10);

        // Reset mid-take after two records: no terminator, restart from address 0.
        b = cyc + 1;
        rec_en = 1'b1; pin_note = 10'h001;
        push(0, 2, 10'h001, b + 23);
        push(1, 2, 10'h002, b + 43);
        before_edge(b + 20);
        pin_note = 10'h002;
        before_edge(b + 40);
        pin_note = 10'h004;
        before_edge(b + 50);
        rst = 1'b1; rec_en = 1'b0;
        before_edge(b + 51);
        check_reset("midrst");
        before_edge(b + 53);
        rst = 1'b0;
        before_edge(b + 80);
        check("midrst_drained", 32'(exp_q.size()), 32'd0);
        b = cyc + 1;
        rec_en = 1'b1; pin_note = 10'h008;
        push(0, 2, 10'h008, b + 23);
        push(1, 2, 10'h001, b + 43);
        push(2, 0, 10'h000, b + 44);
        before_edge(b + 20);
        pin_note = 10'h001;
        before_edge(b + 40);
        rec_en = 1'b0;
        before_edge(b + 55);
        check("restart_len", 32'(rec_len), 32'd2);
        check("restart_drained", 32'(exp_q.size()), 32'd0);

        // rec_en held high through reset starts a take three edges after release.
        b = cyc + 1;
        rst = 1'b1; rec_en = 1'b1; pin_note = 10'h010;
        before_edge(b + 3);
        rst = 1'b0;
        b = b + 3;
        push(0, 3, 10'h010, b + 33);
        push(1, 0, 10'h000, b + 34);
        before_edge(b + 2);
        check("hold_rst_early", 32'(recording), 32'd0);
        before_edge(b + 3);
        check("hold_rst_start", 32'(recording), 32'd1);
        before_edge(b + 30);
        rec_en = 1'b0;
        before_edge(b + 45);
        check("hold_rst_len", 32'(rec_len), 32'd1);
        check("hold_rst_rec", 32'(recording), 32'd0);
        check("hold_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
